// File: rtl/fp16_tree_accum_pkg.sv
// Shared VPE types for the fp16 accumulation stage: data type, constants, FSM states.
package fp16_tree_accum_pkg;

  localparam int unsigned FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  localparam fp16_t FP16_POS_ZERO = 16'h0000;
  localparam fp16_t FP16_QNAN     = 16'h7E00;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/fp16_tree_accum_add.sv
// Combinational two-operand fp16 adder, round-to-nearest-even, subnormals supported.
module new_fp16_add
  import fp16_tree_accum_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_ge, w_sub;
  fp16_t       w_big, w_sml;
  logic [4:0]  w_eb_eff, w_es_eff, w_d;
  logic [10:0] w_mb, w_ms;
  logic [34:0] w_ms_ext;
  logic [13:0] w_ma_al, w_ms_al;
  logic [14:0] w_sum;

  assign w_a_nan = (i_a[14:10] == 5'h1F) && (i_a[9:0] != 10'd0);
  assign w_b_nan = (i_b[14:10] == 5'h1F) && (i_b[9:0] != 10'd0);
  assign w_a_inf = (i_a[14:10] == 5'h1F) && (i_a[9:0] == 10'd0);
  assign w_b_inf = (i_b[14:10] == 5'h1F) && (i_b[9:0] == 10'd0);

  // Order by magnitude so alignment only ever shifts the smaller operand right
  assign w_a_ge   = i_a[14:0] >= i_b[14:0];
  assign w_big    = w_a_ge ? i_a : i_b;
  assign w_sml    = w_a_ge ? i_b : i_a;
  assign w_eb_eff = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
  assign w_es_eff = (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10];
  assign w_mb     = {w_big[14:10] != 5'd0, w_big[9:0]};
  assign w_ms     = {w_sml[14:10] != 5'd0, w_sml[9:0]};
  assign w_d      = w_eb_eff - w_es_eff;
  assign w_ms_ext = {w_ms, 24'd0} >> w_d;
  assign w_ma_al  = {w_mb, 3'b000};
  assign w_ms_al  = {w_ms_ext[34:22], |w_ms_ext[21:0]};
  assign w_sub    = w_big[15] ^ w_sml[15];
  assign w_sum    = w_sub ? ({1'b0, w_ma_al} - {1'b0, w_ms_al})
                          : ({1'b0, w_ma_al} + {1'b0, w_ms_al});

  logic [3:0]  w_lz;
  logic [5:0]  w_exp6, w_sh, w_exp, w_exp_f;
  logic [13:0] w_norm;
  logic [11:0] w_rnd;
  logic [9:0]  w_frac;

  always_comb begin
    w_lz = 4'd13;
    for (int i = 0; i < 14; i++) begin
      if (w_sum[i]) w_lz = 4'(13 - i);
    end
    w_exp6 = {1'b0, w_eb_eff};
    w_sh   = 6'd0;
    if (w_sum[14]) begin
      w_norm = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_exp  = w_exp6 + 6'd1;
    end else begin
      // Normalise left, but never below the subnormal exponent
      w_sh   = ({2'b00, w_lz} < (w_exp6 - 6'd1)) ? {2'b00, w_lz} : (w_exp6 - 6'd1);
      w_norm = w_sum[13:0] << w_sh;
      w_exp  = w_exp6 - w_sh;
    end
    w_rnd   = {1'b0, w_norm[13:3]}
            + 12'(w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]));
    w_exp_f = w_rnd[11] ? (w_exp + 6'd1) : (w_rnd[10] ? w_exp : 6'd0);
    w_frac  = w_rnd[11] ? w_rnd[10:1] : w_rnd[9:0];

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15]))) begin
      o_sum = FP16_QNAN;
    end else if (w_a_inf) begin
      o_sum = i_a;
    end else if (w_b_inf) begin
      o_sum = i_b;
    end else if (w_sum == 15'd0) begin
      o_sum = {w_big[15] & w_sml[15], 15'd0};
    end else if (w_exp_f >= 6'd31) begin
      o_sum = {w_big[15], 5'h1F, 10'd0};
    end else begin
      o_sum = {w_big[15], w_exp_f[4:0], w_frac};
    end
  end

endmodule

// File: rtl/fp16_tree_accum.sv
// Left-folds a stream of fp16 partial sums into one total per vector,
// with a single-entry output buffer and a saturating beat count.
module fp16_tree_accum
  import fp16_tree_accum_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] out_beats_o,
  output logic             out_sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  fp16_t            r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_sat, w_sat_nxt, w_clip;
  logic             r_out_valid, w_out_valid_nxt;
  fp16_t            r_out_data;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_sat;
  logic             w_accept, w_load, w_load_sat;
  fp16_t            w_sum, w_load_data;
  logic [CNT_W-1:0] w_load_beats;

  new_fp16_add u_add (
    .i_a   (r_acc),
    .i_b   (in_data_i),
    .o_sum (w_sum)
  );

  // Stall only while a finished result is waiting and not being taken
  assign in_ready_o = !(r_out_valid && !out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_clip     = (r_cnt == CNT_MAX);
  assign w_cnt_inc  = w_clip ? r_cnt : (r_cnt + CNT_ONE);

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_sat_nxt    = r_sat;
    w_load       = 1'b0;
    w_load_data  = in_data_i;
    w_load_beats = CNT_ONE;
    w_load_sat   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (in_last_i) begin
            w_load = 1'b1;
          end else begin
            w_acc_nxt   = in_data_i;
            w_cnt_nxt   = CNT_ONE;
            w_sat_nxt   = 1'b0;
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (w_accept) begin
          if (in_last_i) begin
            w_load       = 1'b1;
            w_load_data  = w_sum;
            w_load_beats = w_cnt_inc;
            w_load_sat   = r_sat | w_clip;
            w_acc_nxt    = FP16_POS_ZERO;
            w_cnt_nxt    = '0;
            w_sat_nxt    = 1'b0;
            w_state_nxt  = IDLE;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = w_cnt_inc;
            w_sat_nxt = r_sat | w_clip;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A load in the same cycle as a drain keeps the buffer full
    w_out_valid_nxt = r_out_valid;
    if (w_load) begin
      w_out_valid_nxt = 1'b1;
    end else if (r_out_valid && out_ready_i) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= FP16_POS_ZERO;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= FP16_POS_ZERO;
      r_out_beats <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sat       <= w_sat_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_load) begin
        r_out_data  <= w_load_data;
        r_out_beats <= w_load_beats;
        r_out_sat   <= w_load_sat;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_beats_o = r_out_beats;
  assign out_sat_o   = r_out_sat;

endmodule
